// File: rtl/extend_conv.sv
// Wavefront match extension: walks diagonal k from offset h while reference and
// query characters agree, then reports the extended offset and end-of-tile flag.
module extend_conv #(
  parameter int unsigned MAX_TILE_SIZE         = 64,
  parameter int unsigned LOG_MAX_TILE_SIZE     = 6,
  parameter int unsigned LOG_MAX_WAVEFRONT_LEN = 5,
  parameter int unsigned DATA_WIDTH            = 8,
  parameter int unsigned CHAR_WIDTH            = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 startExtend,
  input  logic [LOG_MAX_TILE_SIZE-1:0]         M_in,
  input  logic [LOG_MAX_WAVEFRONT_LEN+2:0]     M_in_ID,
  input  logic                                 valid_M_in,
  input  logic signed [DATA_WIDTH-1:0]         k,
  input  logic [LOG_MAX_TILE_SIZE-1:0]         ref_len,
  input  logic [LOG_MAX_TILE_SIZE-1:0]         query_len,
  output logic [LOG_MAX_TILE_SIZE-1:0]         ref_addr,
  output logic [LOG_MAX_TILE_SIZE-1:0]         query_addr,
  input  logic [CHAR_WIDTH-1:0]                ref_char,
  input  logic [CHAR_WIDTH-1:0]                query_char,
  output logic [LOG_MAX_TILE_SIZE-1:0]         M_out,
  output logic [LOG_MAX_WAVEFRONT_LEN+2:0]     M_out_ID,
  output logic                                 valid_M_out,
  output logic                                 atEnd,
  output logic                                 doneExtend
);

  localparam int unsigned LW = LOG_MAX_TILE_SIZE;
  localparam int unsigned IW = LOG_MAX_WAVEFRONT_LEN + 3;
  localparam int unsigned VW = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [LW-1:0]           h_q, h_d;
  logic signed [DATA_WIDTH-1:0] k_q, k_d;
  logic [LW-1:0]           ref_len_q, ref_len_d;
  logic [LW-1:0]           query_len_q, query_len_d;
  logic [IW-1:0]           id_q, id_d;
  logic                    valid_q, valid_d;
  logic [LW-1:0]           m_out_q, m_out_d;
  logic [IW-1:0]           m_out_id_q, m_out_id_d;
  logic                    valid_out_q, valid_out_d;
  logic                    at_end_q, at_end_d;
  logic                    done_q, done_d;
  logic [LW-1:0]           ref_addr_q, ref_addr_d;
  logic [LW-1:0]           query_addr_q, query_addr_d;

  logic signed [VW-1:0]    h_ext_c;
  logic signed [VW-1:0]    k_ext_c;
  logic signed [VW-1:0]    v_c;
  logic [VW-1:0]           v_u_c;
  logic                    v_neg_c;
  logic                    h_ge_c;
  logic                    v_ge_c;
  logic                    in_bounds_c;
  logic                    at_end_c;
  logic                    issue_c;
  logic                    h_can_inc_c;
  logic                    enter_done_c;

  // Query position on the diagonal: v = h - k, one bit wider than k so it cannot overflow.
  always_comb begin
    h_ext_c     = VW'(h_q);
    k_ext_c     = VW'(k_q);
    v_c         = h_ext_c - k_ext_c;
    v_u_c       = v_c;
    v_neg_c     = v_c[VW-1];
    h_ge_c      = (h_q >= ref_len_q);
    v_ge_c      = (v_u_c >= VW'(query_len_q));
    in_bounds_c = valid_q && !v_neg_c && !h_ge_c && !v_ge_c;
    at_end_c    = valid_q && (h_q == ref_len_q) && !v_neg_c && (v_u_c == VW'(query_len_q));
    issue_c     = (state_q == S_CHECK) && in_bounds_c;
    h_can_inc_c = (h_q < ref_len_q) && ((32'(h_q) + 32'd1) < MAX_TILE_SIZE);
  end

  // Addresses are presented during CHECK so the 1-cycle memory returns data in COMPARE.
  assign ref_addr    = issue_c ? h_q : ref_addr_q;
  assign query_addr  = issue_c ? v_u_c[LW-1:0] : query_addr_q;

  assign M_out       = m_out_q;
  assign M_out_ID    = m_out_id_q;
  assign valid_M_out = valid_out_q;
  assign atEnd       = at_end_q;
  assign doneExtend  = done_q;

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    k_d          = k_q;
    ref_len_d    = ref_len_q;
    query_len_d  = query_len_q;
    id_d         = id_q;
    valid_d      = valid_q;
    m_out_d      = m_out_q;
    m_out_id_d   = m_out_id_q;
    valid_out_d  = valid_out_q;
    at_end_d     = at_end_q;
    done_d       = 1'b0;
    ref_addr_d   = ref_addr_q;
    query_addr_d = query_addr_q;
    enter_done_c = 1'b0;

    if (issue_c) begin
      ref_addr_d   = h_q;
      query_addr_d = v_u_c[LW-1:0];
    end

    case (state_q)
      S_IDLE: begin
        if (startExtend) begin
          h_d         = M_in;
          k_d         = k;
          ref_len_d   = ref_len;
          query_len_d = query_len;
          id_d        = M_in_ID;
          valid_d     = valid_M_in;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (in_bounds_c) begin
          state_d = S_COMPARE;
        end else begin
          state_d      = S_DONE;
          enter_done_c = 1'b1;
        end
      end
      S_COMPARE: begin
        if (ref_char == query_char) begin
          if (h_can_inc_c) begin
            h_d = h_q + LW'(1);
          end
          state_d = S_CHECK;
        end else begin
          state_d      = S_DONE;
          enter_done_c = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Results are captured once, on the transition into DONE.
    if (enter_done_c) begin
      done_d = 1'b1;
      if (valid_q) begin
        m_out_d     = h_q;
        m_out_id_d  = id_q;
        valid_out_d = 1'b1;
        at_end_d    = at_end_c;
      end else begin
        m_out_d     = '0;
        m_out_id_d  = '1;
        valid_out_d = 1'b0;
        at_end_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      h_q          <= '0;
      k_q          <= '0;
      ref_len_q    <= '0;
      query_len_q  <= '0;
      id_q         <= '0;
      valid_q      <= 1'b0;
      m_out_q      <= '0;
      m_out_id_q   <= '0;
      valid_out_q  <= 1'b0;
      at_end_q     <= 1'b0;
      done_q       <= 1'b0;
      ref_addr_q   <= '0;
      query_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      k_q          <= k_d;
      ref_len_q    <= ref_len_d;
      query_len_q  <= query_len_d;
      id_q         <= id_d;
      valid_q      <= valid_d;
      m_out_q      <= m_out_d;
      m_out_id_q   <= m_out_id_d;
      valid_out_q  <= valid_out_d;
      at_end_q     <= at_end_d;
      done_q       <= done_d;
      ref_addr_q   <= ref_addr_d;
      query_addr_q <= query_addr_d;
    end
  end

endmodule

// File: tb/tb_extend_conv.sv
// Bench for extend_conv: tile memories with 1-cycle read latency and a
// character-walking reference model of the diagonal extension.
module tb_extend_conv;

  localparam int unsigned LW = 6;
  localparam int unsigned IW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst;
  logic startExtend;
  logic [LW-1:0] M_in;
  logic [IW-1:0] M_in_ID;
  logic valid_M_in;
  logic signed [DW-1:0] k;
  logic [LW-1:0] ref_len, query_len;
  logic [LW-1:0] ref_addr, query_addr;
  logic [CW-1:0] ref_char, query_char;
  logic [LW-1:0] M_out;
  logic [IW-1:0] M_out_ID;
  logic valid_M_out, atEnd, doneExtend;

  logic [CW-1:0] ref_mem [64];
  logic [CW-1:0] query_mem [64];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ref_char   <= ref_mem[ref_addr];
    query_char <= query_mem[query_addr];
  end

  extend_conv dut (
    .clk(clk), .rst(rst), .startExtend(startExtend),
    .M_in(M_in), .M_in_ID(M_in_ID), .valid_M_in(valid_M_in), .k(k),
    .ref_len(ref_len), .query_len(query_len),
    .ref_addr(ref_addr), .query_addr(query_addr),
    .ref_char(ref_char), .query_char(query_char),
    .M_out(M_out), .M_out_ID(M_out_ID), .valid_M_out(valid_M_out),
    .atEnd(atEnd), .doneExtend(doneExtend)
  );

  // Reference: walk the diagonal one character at a time, two cycles per match.
  function automatic void model(input int h0, input int kk, input bit vld, input int rl,
                                input int ql, output int cyc, output int mo, output bit ae);
    int h, v, n;
    bit stop;
    cyc = 0; mo = 0; ae = 0;
    if (!vld) begin
      cyc = 2;
      return;
    end
    h = h0; n = 0; v = 0; stop = 0;
    while (!stop) begin
      v = h - kk;
      if (v < 0 || h >= rl || v >= ql) begin
        cyc = 2 * n + 2; stop = 1;
      end else if (ref_mem[h] != query_mem[v]) begin
        cyc = 2 * n + 3; stop = 1;
      end else begin
        h++; n++;
      end
    end
    mo = h;
    ae = (h == rl) && (v == ql);
  endfunction

  function automatic logic [CW-1:0] enc(input byte c);
    case (c)
      "A": enc = 2'd0;
      "C": enc = 2'd1;
      "G": enc = 2'd2;
      default: enc = 2'd3;
    endcase
  endfunction

  task automatic load_str(input string r, input string q);
    for (int i = 0; i < 64; i++) begin
      ref_mem[i]   = (i < r.len()) ? enc(r[i]) : 2'd0;
      query_mem[i] = (i < q.len()) ? enc(q[i]) : 2'd0;
    end
  endtask

  task automatic drive(input int m, input int id, input bit vld, input int kk,
                       input int rl, input int ql);
    M_in = LW'(m); M_in_ID = IW'(id); valid_M_in = vld;
    k = DW'(kk); ref_len = LW'(rl); query_len = LW'(ql);
  endtask

  // One extension from start pulse to done; cyc=-1 if the done pulse never arrives.
  task automatic do_run(input int m, input int id, input bit vld, input int kk,
                        input int rl, input int ql, output int cyc, output int mo,
                        output int mid, output bit vo, output bit ae,
                        output int addr_moves, output bit done_again);
    logic [LW-1:0] ra0, qa0;
    @(negedge clk);
    drive(m, id, vld, kk, rl, ql);
    startExtend = 1'b1;
    ra0 = ref_addr; qa0 = query_addr;
    addr_moves = 0; cyc = -1; mo = -1; mid = -1; vo = 0; ae = 0;
    @(posedge clk);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      startExtend = 1'b0;
      if (ref_addr !== ra0 || query_addr !== qa0) addr_moves++;
      if (doneExtend === 1'b1) begin
        cyc = c; mo = int'(M_out); mid = int'(M_out_ID); vo = valid_M_out; ae = atEnd;
        break;
      end
    end
    @(negedge clk);
    done_again = doneExtend;
  endtask

  task automatic test_reset();
    rst = 1'b1; startExtend = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({M_out, M_out_ID, valid_M_out, atEnd, doneExtend} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got M_out=%0d id=%0d v=%b end=%b done=%b, want all 0",
               M_out, M_out_ID, valid_M_out, atEnd, doneExtend);
    end
    total++;
    if (ref_addr !== 6'd0 || query_addr !== 6'd0) begin
      bad++;
      $display("FAIL reset_addr: got %0d/%0d want 0/0", ref_addr, query_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_mismatch();
    int cyc, mo, mid, am; bit vo, ae, da;
    load_str("ACGT", "ACGA");
    do_run(0, 17, 1, 0, 4, 4, cyc, mo, mid, vo, ae, am, da);
    total++;
    if (cyc !== 9 || mo !== 3 || ae !== 1'b0) begin
      bad++;
      $display("FAIL mismatch_run: got cyc=%0d M_out=%0d atEnd=%b want 9/3/0", cyc, mo, ae);
    end
    total++;
    if (mid !== 17 || vo !== 1'b1 || da !== 1'b0) begin
      bad++;
      $display("FAIL mismatch_id: got id=%0d v=%b done_after=%b want 17/1/0", mid, vo, da);
    end
  endtask

  task automatic test_full_match();
    int cyc, mo, mid, am; bit vo, ae, da;
    load_str("ACGT", "ACGT");
    do_run(1, 200, 1, 0, 4, 4, cyc, mo, mid, vo, ae, am, da);
    total++;
    if (cyc !== 8 || mo !== 4 || ae !== 1'b1) begin
      bad++;
      $display("FAIL full_match: got cyc=%0d M_out=%0d atEnd=%b want 8/4/1", cyc, mo, ae);
    end
    total++;
    if (mid !== 200 || vo !== 1'b1) begin
      bad++;
      $display("FAIL full_match_id: got id=%0d v=%b want 200/1", mid, vo);
    end
  endtask

  task automatic test_invalid();
    int cyc, mo, mid, am; bit vo, ae, da;
    do_run(5, 3, 0, 0, 4, 4, cyc, mo, mid, vo, ae, am, da);
    total++;
    if (cyc !== 2 || mo !== 0 || mid !== 255 || vo !== 1'b0 || ae !== 1'b0) begin
      bad++;
      $display("FAIL invalid_run: got cyc=%0d M_out=%0d id=%0d v=%b end=%b want 2/0/255/0/0",
               cyc, mo, mid, vo, ae);
    end
    total++;
    if (am !== 0) begin
      bad++;
      $display("FAIL invalid_addr: got %0d address changes want 0", am);
    end
  endtask

  task automatic test_neg_diag();
    int cyc, mo, mid, am; bit vo, ae, da;
    load_str("ACGT", "ACGT");
    do_run(1, 9, 1, 3, 4, 4, cyc, mo, mid, vo, ae, am, da);
    total++;
    if (cyc !== 2 || mo !== 1 || ae !== 1'b0 || vo !== 1'b1) begin
      bad++;
      $display("FAIL neg_diag: got cyc=%0d M_out=%0d end=%b v=%b want 2/1/0/1", cyc, mo, ae, vo);
    end
  endtask

  task automatic test_reset_midrun();
    int dones, cyc, mo, mid, am; bit vo, ae, da;
    load_str("AAAAAAAAAAAA", "AAAAAAAAAAAA");
    dones = 0;
    @(negedge clk);
    drive(0, 33, 1, 0, 12, 12);
    startExtend = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      startExtend = 1'b0;
      if (doneExtend === 1'b1) dones++;
      if (c == 6) rst = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({M_out, M_out_ID, valid_M_out, atEnd, doneExtend, ref_addr, query_addr} !== '0) begin
      bad++;
      $display("FAIL midrun_reset_outputs: got M_out=%0d id=%0d v=%b end=%b ra=%0d qa=%0d",
               M_out, M_out_ID, valid_M_out, atEnd, ref_addr, query_addr);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (doneExtend === 1'b1) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL midrun_no_done: got %0d done pulses want 0", dones);
    end
    load_str("AA", "AA");
    do_run(0, 5, 1, 0, 2, 2, cyc, mo, mid, vo, ae, am, da);
    total++;
    if (cyc !== 6 || mo !== 2 || ae !== 1'b1 || mid !== 5) begin
      bad++;
      $display("FAIL after_reset_run: got cyc=%0d M_out=%0d end=%b id=%0d want 6/2/1/5",
               cyc, mo, ae, mid);
    end
  endtask

  task automatic test_random();
    int cyc, mo, mid, am, kk, rl, ql, m, id, ecyc, emo, idx; bit vo, ae, da, vld, eae;
    for (int it = 0; it < 40; it++) begin
      kk = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) - 128
                                        : int'($urandom_range(0, 8)) - 4;
      for (int j = 0; j < 64; j++) ref_mem[j] = CW'($urandom_range(0, 3));
      for (int j = 0; j < 64; j++) begin
        idx = j + kk;
        query_mem[j] = (idx >= 0 && idx < 64 && $urandom_range(0, 7) != 0)
                       ? ref_mem[idx] : CW'($urandom_range(0, 3));
      end
      rl  = int'($urandom_range(0, 63));
      ql  = int'($urandom_range(0, 63));
      m   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, rl));
      id  = int'($urandom_range(0, 255));
      vld = ($urandom_range(0, 9) != 0);
      model(m, kk, vld, rl, ql, ecyc, emo, eae);
      do_run(m, id, vld, kk, rl, ql, cyc, mo, mid, vo, ae, am, da);
      total++;
      if (cyc !== ecyc || mo !== emo || ae !== eae || vo !== vld ||
          mid !== (vld ? id : 255) || da !== 1'b0) begin
        bad++;
        $display("FAIL random_%0d: got cyc=%0d M_out=%0d end=%b v=%b id=%0d want %0d/%0d/%b/%b/%0d",
                 it, cyc, mo, ae, vo, mid, ecyc, emo, eae, vld, vld ? id : 255);
      end
      if (!vld) begin
        total++;
        if (am !== 0) begin
          bad++;
          $display("FAIL random_addr_%0d: got %0d address changes want 0", it, am);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int bm[4], bk[4], brl[4], bql[4], bid[4], ecyc[4], emo[4];
    bit bv[4], eae[4];
    int run, c, dones;
    for (int j = 0; j < 64; j++) begin
      ref_mem[j]   = ($urandom_range(0, 9) < 8) ? 2'd0 : CW'($urandom_range(1, 3));
      query_mem[j] = ($urandom_range(0, 9) < 8) ? 2'd0 : CW'($urandom_range(1, 3));
    end
    for (int r = 0; r < 4; r++) begin
      brl[r] = int'($urandom_range(8, 40));
      bql[r] = int'($urandom_range(8, 40));
      bm[r]  = int'($urandom_range(0, 6));
      bk[r]  = int'($urandom_range(0, 4)) - 2;
      bid[r] = int'($urandom_range(0, 254));
      bv[r]  = (r != 2);
      model(bm[r], bk[r], bv[r], brl[r], bql[r], ecyc[r], emo[r], eae[r]);
    end
    @(negedge clk);
    drive(bm[0], bid[0], bv[0], bk[0], brl[0], bql[0]);
    startExtend = 1'b1;
    run = 0; c = 0; dones = 0;
    for (int t = 0; t < 2000; t++) begin
      if (run >= 4) break;
      @(negedge clk);
      c++;
      if (c == 1) drive(int'($urandom_range(0, 63)), int'($urandom_range(0, 255)),
                        $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)) - 128,
                        int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      if (doneExtend === 1'b1) begin
        dones++;
        total++;
        if (c !== ecyc[run] || int'(M_out) !== emo[run] || atEnd !== eae[run] ||
            valid_M_out !== bv[run] || int'(M_out_ID) !== (bv[run] ? bid[run] : 255)) begin
          bad++;
          $display("FAIL b2b_run_%0d: got cyc=%0d M_out=%0d end=%b v=%b id=%0d want %0d/%0d/%b/%b",
                   run, c, M_out, atEnd, valid_M_out, M_out_ID, ecyc[run], emo[run],
                   eae[run], bv[run]);
        end
        run++;
        if (run < 4) drive(bm[run], bid[run], bv[run], bk[run], brl[run], bql[run]);
        else startExtend = 1'b0;
        c = -1;
      end
    end
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (doneExtend === 1'b1) dones++;
    end
    total++;
    if (dones !== 4) begin
      bad++;
      $display("FAIL b2b_done_count: got %0d done pulses want 4", dones);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = '0;
      query_mem[i] = '0;
    end
    test_reset();
    test_mismatch();
    test_full_match();
    test_invalid();
    test_neg_diag();
    test_reset_midrun();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
